// File: rtl/rs_fifo_grace.sv
// Terminating FWFT FIFO for a chain of registered relay stages. Deasserts if_full_n
// GRACE entries early so that writes already in flight are still stored.
module rs_fifo_grace #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 16,
   parameter int unsigned GRACE      = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   output logic                          if_full_n,
   input  logic                          if_write,
   input  logic [DATA_WIDTH-1:0]         if_din,
   output logic                          if_empty_n,
   input  logic                          if_read,
   output logic [DATA_WIDTH-1:0]         if_dout,
   output logic [$clog2(DEPTH+1)-1:0]    occupancy,
   output logic                          overflow
);

   localparam int unsigned CntW = $clog2(DEPTH + 1);
   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam logic [CntW-1:0] CntDepth = CntW'(DEPTH);
   localparam logic [CntW-1:0] CntThr   = CntW'(DEPTH - GRACE);
   localparam logic [PtrW-1:0] PtrLast  = PtrW'(DEPTH - 1);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [CntW-1:0]       count_q, count_d;
   logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic                  full_n_q, full_n_d;
   logic                  empty_n_q, empty_n_d;
   logic                  overflow_q, overflow_d;
   logic                  wr_en, rd_en;

   // Writes are not gated by full_n: in-flight writes land in the grace slack.
   always_comb begin
      rd_en = if_read && empty_n_q;
      wr_en = if_write && ((count_q < CntDepth) || rd_en);
   end

   always_comb begin
      count_d    = count_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      overflow_d = overflow_q || (if_write && !wr_en);
      unique case ({wr_en, rd_en})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
      if (wr_en) wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + PtrW'(1);
      if (rd_en) rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + PtrW'(1);
      full_n_d  = count_d < CntThr;
      empty_n_d = count_d != '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q    <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         full_n_q   <= 1'b0;
         empty_n_q  <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         count_q    <= count_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         full_n_q   <= full_n_d;
         empty_n_q  <= empty_n_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage is deliberately left unreset.
   always_ff @(posedge clk) begin
      if (!reset && wr_en) mem_q[wr_ptr_q] <= if_din;
   end

   assign if_dout    = mem_q[rd_ptr_q];
   assign if_full_n  = full_n_q;
   assign if_empty_n = empty_n_q;
   assign occupancy  = count_q;
   assign overflow   = overflow_q;

endmodule

// File: tb/tb_rs_fifo_grace.sv
// Scoreboard bench for rs_fifo_grace: driver pushes expected data, a negedge
// monitor pops and compares whenever the consumer takes a word.
module tb_rs_fifo_grace;

   localparam int unsigned DW = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          if_full_n, if_empty_n, overflow;
   logic          if_write, if_read;
   logic [DW-1:0] if_din, if_dout;
   logic [4:0]    occupancy;

   int n_pass = 0;
   int n_total = 0;
   logic [DW-1:0] exp_q[$];
   int model_cnt = 0;

   always #5 clk = ~clk;

   rs_fifo_grace #(.DATA_WIDTH(32), .DEPTH(16), .GRACE(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .if_full_n  (if_full_n),
      .if_write   (if_write),
      .if_din     (if_din),
      .if_empty_n (if_empty_n),
      .if_read    (if_read),
      .if_dout    (if_dout),
      .occupancy  (occupancy),
      .overflow   (overflow)
   );

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      else n_pass++;
   endtask

   // Monitor: a read is taken when if_read && if_empty_n at the edge.
   always @(negedge clk) begin
      if (!reset && if_read && if_empty_n) begin
         if (exp_q.size() == 0) check("unexpected_read", if_dout, 32'hDEAD_BEEF);
         else check("dout", if_dout, exp_q.pop_front());
      end
   end

   // Drive one cycle; expected acceptance follows the documented handshake rules.
   task automatic step(input logic wr, input logic [DW-1:0] din, input logic rd);
      bit rd_ok, wr_ok;
      if_write = wr;
      if_din   = din;
      if_read  = rd;
      rd_ok = rd && (model_cnt != 0);
      wr_ok = wr && (model_cnt < 16 || rd_ok);
      if (wr_ok) exp_q.push_back(din);
      model_cnt = model_cnt + int'(wr_ok) - int'(rd_ok);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int n);
      reset    = 1'b1;
      if_write = 1'b0;
      if_read  = 1'b0;
      if_din   = '0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         check("full_n_in_reset", {31'b0, if_full_n}, 32'd0);
      end
      exp_q.delete();
      model_cnt = 0;
      reset = 1'b0;
      check("full_n_first_cycle", {31'b0, if_full_n}, 32'd0);
      step(1'b0, '0, 1'b0);
      check("full_n_after_release", {31'b0, if_full_n}, 32'd1);
      check("empty_n_reset", {31'b0, if_empty_n}, 32'd0);
      check("occ_reset", {27'b0, occupancy}, 32'd0);
      check("ovf_reset", {31'b0, overflow}, 32'd0);
   endtask

   initial begin
      reset = 1'b1; if_write = 1'b0; if_read = 1'b0; if_din = '0;
      @(posedge clk);
      #1;

      // 1. reset and first idle cycle
      do_reset(3);

      // 2. twelve writes; full_n falls on the twelfth
      for (int i = 0; i < 12; i++) begin
         step(1'b1, 32'h100 + i, 1'b0);
         if (i == 10) check("full_n_at_11", {31'b0, if_full_n}, 32'd1);
      end
      check("full_n_at_12", {31'b0, if_full_n}, 32'd0);
      check("occ_12", {27'b0, occupancy}, 32'd12);
      check("dout_head", if_dout, 32'h100);
      check("empty_n_12", {31'b0, if_empty_n}, 32'd1);

      // 3. fill to 16, drop one, drain in order
      for (int i = 12; i < 16; i++) step(1'b1, 32'h100 + i, 1'b0);
      check("occ_16", {27'b0, occupancy}, 32'd16);
      check("ovf_before_drop", {31'b0, overflow}, 32'd0);
      step(1'b1, 32'h110, 1'b0);
      check("occ_after_drop", {27'b0, occupancy}, 32'd16);
      check("ovf_after_drop", {31'b0, overflow}, 32'd1);
      for (int i = 0; i < 16; i++) begin
         step(1'b0, '0, 1'b1);
         if (i == 3) check("full_n_occ12", {31'b0, if_full_n}, 32'd0);
         if (i == 4) check("full_n_occ11", {31'b0, if_full_n}, 32'd1);
      end
      step(1'b0, '0, 1'b0);
      check("occ_drained", {27'b0, occupancy}, 32'd0);
      check("empty_n_drained", {31'b0, if_empty_n}, 32'd0);
      check("ovf_sticky", {31'b0, overflow}, 32'd1);
      check("sb_empty_3", exp_q.size(), 32'd0);

      // 4. simultaneous read and write when full
      do_reset(1);
      for (int i = 0; i < 16; i++) step(1'b1, 32'h100 + i, 1'b0);
      step(1'b1, 32'hAAA, 1'b1);
      check("occ_full_rw", {27'b0, occupancy}, 32'd16);
      check("ovf_full_rw", {31'b0, overflow}, 32'd0);
      check("head_after_rw", if_dout, 32'h101);
      for (int i = 0; i < 16; i++) step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b0);
      check("sb_empty_4", exp_q.size(), 32'd0);
      check("occ_after_4", {27'b0, occupancy}, 32'd0);

      // 5. simultaneous read and write when empty
      step(1'b1, 32'h55, 1'b1);
      check("occ_empty_rw", {27'b0, occupancy}, 32'd1);
      check("empty_n_empty_rw", {31'b0, if_empty_n}, 32'd1);
      check("dout_empty_rw", if_dout, 32'h55);
      step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b0);
      check("occ_after_5", {27'b0, occupancy}, 32'd0);

      // 6. stream across pointer wrap, then reset with entries queued
      for (int i = 0; i < 40; i++) begin
         step(1'b1, 32'h200 + i, 1'b1);
         check("occ_stream_le1", {31'b0, occupancy <= 5'd1}, 32'd1);
      end
      step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b0);
      check("occ_after_stream", {27'b0, occupancy}, 32'd0);
      check("ovf_stream", {31'b0, overflow}, 32'd0);
      check("sb_empty_6", exp_q.size(), 32'd0);
      for (int i = 0; i < 5; i++) step(1'b1, 32'h300 + i, 1'b0);
      check("occ_5", {27'b0, occupancy}, 32'd5);
      reset = 1'b1; if_write = 1'b0; if_read = 1'b0;
      @(posedge clk);
      #1;
      exp_q.delete();
      model_cnt = 0;
      check("rst_mid_occ", {27'b0, occupancy}, 32'd0);
      check("rst_mid_empty_n", {31'b0, if_empty_n}, 32'd0);
      check("rst_mid_full_n", {31'b0, if_full_n}, 32'd0);
      check("rst_mid_ovf", {31'b0, overflow}, 32'd0);
      reset = 1'b0;
      step(1'b0, '0, 1'b0);
      check("full_n_after_mid_rst", {31'b0, if_full_n}, 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
